// File: rtl/rv32_alu_arbiter.sv
// Two-requester front end for one shared RV32 ALU: IDLE -> EXEC -> HOLD, one op in flight.
// Define RV32_ALU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module rv32_alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_opsel,
    input  logic [31:0] req0_s1,
    input  logic [31:0] req0_s2,
    input  logic [31:0] req0_pc,
    input  logic [31:0] req0_code,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_opsel,
    input  logic [31:0] req1_s1,
    input  logic [31:0] req1_s2,
    input  logic [31:0] req1_pc,
    input  logic [31:0] req1_code,
    output logic [31:0] alu_s1,
    output logic [31:0] alu_s2,
    output logic [31:0] alu_pc,
    output logic [31:0] alu_code,
    output logic [3:0]  alu_opsel,
    output logic        alu_enable,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [1:0]  state,
    output logic        last_grant
);

    // Handshake: an op transfers in a cycle where reqN_valid && reqN_ready (ready may depend
    // on valid); a response transfers where rsp_valid && rsp_ready. Debug state: 0 IDLE, 1 EXEC, 2 HOLD.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic        can_accept;
    logic        grant;
    logic        accept;
    logic [3:0]  op_opsel;
    logic [31:0] op_s1;
    logic [31:0] op_s2;
    logic [31:0] op_pc;
    logic [31:0] op_code;
    logic        op_id;

    assign state      = cur_state;
    assign can_accept = rst_n && ((cur_state == IDLE) || ((cur_state == HOLD) && rsp_ready));
    assign accept     = can_accept && (req0_valid || req1_valid);
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef RV32_ALU_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (accept) nxt_state = EXEC;
            EXEC:    nxt_state = HOLD;
            HOLD:    if (rsp_ready) nxt_state = accept ? EXEC : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Operands reach the ALU only while executing so it sees no toggling otherwise.
    always_comb begin
        alu_enable = 1'b0;
        alu_opsel  = 4'd0;
        alu_s1     = 32'd0;
        alu_s2     = 32'd0;
        alu_pc     = 32'd0;
        alu_code   = 32'd0;
        if (cur_state == EXEC) begin
            alu_enable = 1'b1;
            alu_opsel  = op_opsel;
            alu_s1     = op_s1;
            alu_s2     = op_s2;
            alu_pc     = op_pc;
            alu_code   = op_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_opsel   <= 4'd0;
            op_s1      <= 32'd0;
            op_s2      <= 32'd0;
            op_pc      <= 32'd0;
            op_code    <= 32'd0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_id     <= 1'b0;
        end else begin
            if (accept) begin
                op_opsel   <= grant ? req1_opsel : req0_opsel;
                op_s1      <= grant ? req1_s1    : req0_s1;
                op_s2      <= grant ? req1_s2    : req0_s2;
                op_pc      <= grant ? req1_pc    : req0_pc;
                op_code    <= grant ? req1_code  : req0_code;
                op_id      <= grant;
                last_grant <= grant;
            end
            if (cur_state == EXEC) begin
                rsp_data <= alu_result;
                rsp_id   <= op_id;
            end
            rsp_valid <= (cur_state == EXEC) || (rsp_valid && !rsp_ready);
        end
    end

endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Bench for rv32_alu_arbiter: cycle-level occupancy model, per-requester op queues and a
// response scoreboard. Builds with or without RV32_ALU_ARB_RR_EN.
module tb_rv32_alu_arbiter;

    typedef struct packed {
        logic [3:0]  opsel;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] pc;
        logic [31:0] code;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_opsel, req1_opsel, alu_opsel;
    logic [31:0] req0_s1, req0_s2, req0_pc, req0_code;
    logic [31:0] req1_s1, req1_s2, req1_pc, req1_code;
    logic [31:0] alu_s1, alu_s2, alu_pc, alu_code, alu_result, rsp_data;
    logic        alu_enable, rsp_valid, rsp_ready, rsp_id, last_grant;
    logic [1:0]  state;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    op_t q0[$];
    op_t q1[$];
    logic [32:0] exp_q[$];
    int grant_log[$];
    int acc_cyc[$];
    int rsp_cyc[$];
    int en_cnt;
    logic [32:0] last_rsp;

    // Model: an op is executing (m_inflight) or its response is outstanding (m_resp).
    logic m_inflight = 1'b0;
    logic m_resp     = 1'b0;
    logic m_last     = 1'b1;
    logic prev_rsp_valid = 1'b0;
    op_t  m_op;
    int   rdy_mode = 0;
    int   bp_cnt   = 0;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc,
                                          input logic [31:0] code);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return pc + 32'd4;
            4'd7:    return code;
            default: return ~a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_opsel, alu_s1, alu_s2, alu_pc, alu_code);

    rv32_alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opsel(req0_opsel),
        .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_pc(req0_pc), .req0_code(req0_code),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opsel(req1_opsel),
        .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_pc(req1_pc), .req1_code(req1_code),
        .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_pc(alu_pc), .alu_code(alu_code),
        .alu_opsel(alu_opsel), .alu_enable(alu_enable), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .state(state), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    function automatic op_t rand_op();
        op_t o;
        o.opsel = 4'($urandom_range(0, 8));
        o.s1    = $urandom;
        o.s2    = $urandom;
        o.pc    = $urandom;
        o.code  = $urandom;
        return o;
    endfunction

    task automatic drive();
        op_t o0, o1;
        o0 = (q0.size() > 0) ? q0[0] : rand_op();
        o1 = (q1.size() > 0) ? q1[0] : rand_op();
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        {req0_opsel, req0_s1, req0_s2, req0_pc, req0_code} = o0;
        {req1_opsel, req1_s1, req1_s2, req1_pc, req1_code} = o1;
        case (rdy_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = 1'($urandom_range(0, 1));
            default: begin
                if (m_resp && bp_cnt < 5) begin
                    rsp_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    rsp_ready = 1'b1;
                end
            end
        endcase
    endtask

    // One clock: check DUT against model mid-cycle, advance model at the edge, drive next inputs.
    task automatic step();
        logic exp_r0, exp_r1;
        int   g;
        op_t  exp_alu;
        #1;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        g = -1;
        if (rst_n && !m_inflight && (!m_resp || rsp_ready)) begin
            if (req0_valid && req1_valid) begin
`ifdef RV32_ALU_ARB_RR_EN
                g = (m_last == 1'b0) ? 1 : 0;
`else
                g = 0;
`endif
            end else if (req0_valid) begin
                g = 0;
            end else if (req1_valid) begin
                g = 1;
            end
            exp_r0 = (g == 0);
            exp_r1 = (g == 1);
        end
        vectors++;
        if ({req0_ready, req1_ready} !== {exp_r0, exp_r1}) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, {req0_ready, req1_ready}, {exp_r0, exp_r1});
        end
        vectors++;
        if (alu_enable !== m_inflight) begin
            errors++;
            $display("FAIL alu_enable cyc=%0d got=%b exp=%b", cyc, alu_enable, m_inflight);
        end
        exp_alu = m_inflight ? m_op : '0;
        vectors++;
        if ({alu_opsel, alu_s1, alu_s2, alu_pc, alu_code} !== exp_alu) begin
            errors++;
            $display("FAIL alu_operands cyc=%0d got=%h exp=%h", cyc,
                     {alu_opsel, alu_s1, alu_s2, alu_pc, alu_code}, exp_alu);
        end
        vectors++;
        if (rsp_valid !== m_resp) begin
            errors++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_resp);
        end
        if (m_resp && exp_q.size() > 0) begin
            vectors++;
            if ({rsp_id, rsp_data} !== exp_q[0]) begin
                errors++;
                $display("FAIL rsp_payload cyc=%0d got=%h exp=%h", cyc, {rsp_id, rsp_data}, exp_q[0]);
            end
        end
        if (rst_n && req0_valid && req0_ready) begin
            grant_log.push_back(0);
            acc_cyc.push_back(cyc);
        end
        if (rst_n && req1_valid && req1_ready) begin
            grant_log.push_back(1);
            acc_cyc.push_back(cyc);
        end
        if (rsp_valid === 1'b1 && !prev_rsp_valid) rsp_cyc.push_back(cyc);
        prev_rsp_valid = (rsp_valid === 1'b1);
        if (alu_enable === 1'b1) en_cnt++;
        if (rst_n && rsp_valid && rsp_ready) last_rsp = {rsp_id, rsp_data};

        @(posedge clk);
        if (!rst_n) begin
            m_inflight = 1'b0;
            m_resp     = 1'b0;
            m_last     = 1'b1;
            exp_q.delete();
        end else begin
            if (m_resp && rsp_ready) begin
                m_resp = 1'b0;
                bp_cnt = 0;
                void'(exp_q.pop_front());
            end
            if (m_inflight) begin
                m_inflight = 1'b0;
                m_resp     = 1'b1;
            end
            if (g >= 0) begin
                m_op = (g == 1) ? q1.pop_front() : q0.pop_front();
                m_inflight = 1'b1;
                m_last = 1'(g);
                exp_q.push_back({1'(g), alu_f(m_op.opsel, m_op.s1, m_op.s2, m_op.pc, m_op.code)});
            end
        end
        #1;
        drive();
        cyc++;
    endtask

    task automatic run(input int max_cycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_inflight || m_resp) && n < max_cycles) begin
            step();
            n++;
        end
        vectors++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL drain_timeout got=%0d cycles exp=<%0d", n, max_cycles);
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        op_t o;
        o = rand_op();
        q0.push_back(o);
        q1.push_back(o);
        drive();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if ({state, rsp_valid, rsp_id, rsp_data, alu_enable, last_grant} !== {2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h",
                     {state, rsp_valid, rsp_id, rsp_data, alu_enable, last_grant},
                     {2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1});
        end
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        drive();
        step();
    endtask

    task automatic test_single_op();
        op_t o;
        o = '{opsel: 4'd0, s1: 32'd5, s2: 32'd7, pc: 32'h100, code: 32'h33};
        rdy_mode = 0;
        acc_cyc.delete();
        rsp_cyc.delete();
        en_cnt = 0;
        last_rsp = '0;
        q0.push_back(o);
        drive();
        run(20);
        step();
        vectors++;
        if (last_rsp !== {1'b0, 32'd12}) begin
            errors++;
            $display("FAIL single_result got=%h exp=%h", last_rsp, {1'b0, 32'd12});
        end
        vectors++;
        if (acc_cyc.size() != 1 || rsp_cyc.size() != 1 || rsp_cyc[0] - acc_cyc[0] != 2) begin
            errors++;
            $display("FAIL single_latency got=%0d exp=2",
                     (acc_cyc.size() == 1 && rsp_cyc.size() == 1) ? rsp_cyc[0] - acc_cyc[0] : -1);
        end
        vectors++;
        if (en_cnt != 1) begin
            errors++;
            $display("FAIL single_alu_enable_cycles got=%0d exp=1", en_cnt);
        end
    endtask

    task automatic test_backpressure();
        op_t o;
        o = '{opsel: 4'd0, s1: 32'd5, s2: 32'd7, pc: 32'h200, code: 32'h33};
        rdy_mode = 2;
        bp_cnt = 0;
        last_rsp = '0;
        q0.push_back(o);
        q0.push_back(rand_op());
        q1.push_back(rand_op());
        drive();
        run(60);
        vectors++;
        if (bp_cnt != 0) begin
            errors++;
            $display("FAIL backpressure_release got=%0d exp=0", bp_cnt);
        end
        rdy_mode = 0;
        drive();
    endtask

    task automatic test_contention();
        int exp_g;
        apply_reset(2);
        rdy_mode = 0;
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        drive();
        run(100);
        vectors++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL contention_count got=%0d exp=8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
`ifdef RV32_ALU_ARB_RR_EN
                exp_g = i % 2;
`else
                exp_g = i / 4;
`endif
                vectors++;
                if (grant_log[i] != exp_g) begin
                    errors++;
                    $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, grant_log[i], exp_g);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 0;
        grant_log.delete();
        acc_cyc.delete();
        for (int i = 0; i < 3; i++) q1.push_back(rand_op());
        drive();
        run(40);
        vectors++;
        if (acc_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=3", acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (acc_cyc[i] - acc_cyc[i-1] != 2 || grant_log[i] != 1) begin
                    errors++;
                    $display("FAIL b2b_spacing idx=%0d got=%0d/%0d exp=2/1", i,
                             acc_cyc[i] - acc_cyc[i-1], grant_log[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        rdy_mode = 0;
        q0.push_back(rand_op());
        drive();
        while (!m_inflight && n < 10) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        q1.push_back(rand_op());
        drive();
        step();
        vectors++;
        if ({state, rsp_valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_op got=%b exp=%b", {state, rsp_valid}, 3'b000);
        end
        q1.delete();
        rst_n = 1'b1;
        drive();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_random();
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) q0.push_back(rand_op());
            else q1.push_back(rand_op());
        end
        drive();
        run(3000);
        rdy_mode = 0;
        drive();
    endtask

    initial begin
        rst_n = 1'b0;
        drive();
        @(posedge clk);
        #2;
        test_reset();
        test_single_op();
        test_backpressure();
        test_contention();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
